// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions (state encoding, default frame shape).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int unsigned c_DEF_OVERSAMPLE = 16;
  localparam int unsigned c_DEF_DATA_BITS  = 8;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_START = c_ST_START,
    ST_DATA  = c_ST_DATA,
    ST_STOP  = c_ST_STOP
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer with a parameterised reset value.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampling UART receiver, LSB first, one stop bit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = c_DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = c_DEF_DATA_BITS
) (
  input  logic                 baud_clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned     c_CW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned     c_IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(OVERSAMPLE - 1);
  localparam logic [c_CW-1:0] c_CNT_MID  = c_CW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DATA_BITS - 1);
  localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);

  logic                 w_rx_s;
  logic                 r_rx_prev;
  uart_state_t          r_state,      w_state_nxt;
  logic [c_CW-1:0]      r_cnt,        w_cnt_nxt;
  logic [c_IW-1:0]      r_idx,        w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,      w_shift_nxt;
  logic [DATA_BITS-1:0] r_data_out,   w_data_out_nxt;
  logic                 r_data_valid, w_data_valid_nxt;
  logic                 r_frame_err,  w_frame_err_nxt;

  // Reset to the idle level so leaving reset never looks like a start edge.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (baud_clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (w_rx_s)
  );

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_prev    <= 1'b1;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_prev    <= w_rx_s;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_shift_nxt      = r_shift;
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !w_rx_s) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = '0;
        end
      end
      ST_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (r_cnt == c_CNT_MID) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      ST_DATA: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx + c_IDX_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      ST_STOP: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          if (w_rx_s) begin
            w_data_out_nxt   = r_shift;
            w_data_valid_nxt = 1'b1;
          end else begin
            w_frame_err_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx against a sample-time frame model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
  // Edges from the one that first captures a low line to the data_valid edge:
  // one edge into the first synchronizer flop, then OS/2 + (DB+1)*OS + 1.
  localparam int c_LAT_FROM_CAPTURE = 1 + OS / 2 + (DB + 1) * OS + 1;

  logic          baud_clk;
  logic          rst_n;
  logic          rx_in;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  uart_rx #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .baud_clk   (baud_clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: the line as seen after the synchronizer, judged at the
  // sample instants counted from the detected start edge.
  logic          m_meta = 1'b1, m_s = 1'b1, m_prev = 1'b1;
  bit            m_active = 1'b0;
  int            m_t0 = 0;
  logic [DB-1:0] m_byte = '0;
  logic [DB-1:0] m_dout = '0;
  bit            m_ev, m_ef;
  int            ecnt = 0;
  int            nvalid = 0, nferr = 0, last_valid_edge = 0;
  logic [DB-1:0] vals[$];
  logic          smp_rx, smp_rst;
  int            j, b;

  always @(posedge baud_clk) begin
    smp_rx  = rx_in;
    smp_rst = rst_n;
    ecnt++;
    #1;
    m_ev = 1'b0;
    m_ef = 1'b0;
    if (!smp_rst) begin
      m_meta = 1'b1; m_s = 1'b1; m_prev = 1'b1;
      m_active = 1'b0;
      m_dout = '0;
    end else begin
      if (!m_active) begin
        if (m_prev && !m_s) begin
          m_active = 1'b1;
          m_t0 = ecnt;
        end
      end else begin
        j = ecnt - m_t0;
        if (j == OS / 2) begin
          if (m_s) m_active = 1'b0;
        end else if (j > OS / 2 && ((j - OS / 2) % OS) == 0) begin
          b = (j - OS / 2) / OS - 1;
          if (b < DB) begin
            m_byte[b] = m_s;
          end else begin
            m_active = 1'b0;
            if (m_s) begin
              m_dout = m_byte;
              m_ev = 1'b1;
            end else begin
              m_ef = 1'b1;
            end
          end
        end
      end
      m_prev = m_s;
      m_s = m_meta;
      m_meta = smp_rx;
    end

    chk("data_out", int'(data_out), int'(m_dout));
    chk("data_valid", int'(data_valid), int'(m_ev));
    chk("frame_err", int'(frame_err), int'(m_ef));
    chk("busy", int'(busy), int'(m_active));
    if (data_valid && frame_err) chk("valid_and_ferr", 1, 0);
    if (data_valid) begin
      nvalid++;
      last_valid_edge = ecnt;
      vals.push_back(data_out);
      chk("busy_at_valid", int'(busy), 0);
    end
    if (frame_err) nferr++;
  end

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int stop_len);
    hold(1'b0, OS);
    for (int i = 0; i < DB; i++) hold(d[i], OS);
    hold(stop, stop_len);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge baud_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  int v0, f0, e0, kind, n;
  logic [DB-1:0] rb;

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge baud_clk);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    hold(1'b1, 5);

    // 0xA5, good stop bit
    v0 = nvalid; f0 = nferr; e0 = ecnt + 1;
    send_frame(8'hA5, 1'b1, OS);
    hold(1'b1, 4);
    chk("a5_pulses", nvalid - v0, 1);
    chk("a5_ferr", nferr - f0, 0);
    chk("a5_data", int'(data_out), 8'hA5);
    chk("a5_latency", last_valid_edge - e0, c_LAT_FROM_CAPTURE);

    // short low glitch
    v0 = nvalid; f0 = nferr;
    hold(1'b0, 4);
    hold(1'b1, 20);
    chk("glitch_valid", nvalid - v0, 0);
    chk("glitch_ferr", nferr - f0, 0);
    chk("glitch_data", int'(data_out), 8'hA5);
    chk("glitch_busy", int'(busy), 0);

    // 0x3C with a low stop bit
    v0 = nvalid; f0 = nferr;
    send_frame(8'h3C, 1'b0, OS);
    hold(1'b1, 20);
    chk("ferr_pulses", nferr - f0, 1);
    chk("ferr_valid", nvalid - v0, 0);
    chk("ferr_data", int'(data_out), 8'hA5);

    // back-to-back: next start right after the stop-bit midpoint
    v0 = nvalid;
    send_frame(8'h00, 1'b1, OS / 2 + 1);
    send_frame(8'hFF, 1'b1, OS / 2 + 1);
    hold(1'b1, 20);
    chk("b2b_pulses", nvalid - v0, 2);
    if (vals.size() >= 2) begin
      chk("b2b_first", int'(vals[vals.size() - 2]), 8'h00);
      chk("b2b_second", int'(vals[vals.size() - 1]), 8'hFF);
    end else begin
      chk("b2b_queue", vals.size(), 2);
    end

    // reset during data bit 3 of 0x5A, then a clean 0xC3
    v0 = nvalid; f0 = nferr;
    hold(1'b0, OS);
    hold(1'b0, OS);
    hold(1'b1, OS);
    hold(1'b0, OS);
    hold(1'b1, OS / 2);
    pulse_reset();
    hold(1'b1, OS * 12);
    chk("abort_valid", nvalid - v0, 0);
    chk("abort_ferr", nferr - f0, 0);
    chk("abort_data", int'(data_out), 0);
    send_frame(8'hC3, 1'b1, OS);
    hold(1'b1, 20);
    chk("c3_pulses", nvalid - v0, 1);
    chk("c3_data", int'(data_out), 8'hC3);

    // transmitter-style frame, bit grid offset by 7 cycles
    v0 = nvalid; f0 = nferr;
    hold(1'b1, 7);
    send_frame(8'h81, 1'b1, OS);
    hold(1'b1, 20);
    chk("tx_pulses", nvalid - v0, 1);
    chk("tx_ferr", nferr - f0, 0);
    chk("tx_data", int'(data_out), 8'h81);

    // randomized traffic, judged by the model every cycle
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 9));
      rb = DB'($urandom);
      if (kind <= 5) begin
        send_frame(rb, 1'b1, int'($urandom_range(OS / 2 + 1, OS + 4)));
      end else if (kind == 6) begin
        send_frame(rb, 1'b0, OS);
      end else if (kind == 7) begin
        hold(1'b0, int'($urandom_range(1, OS / 2 + 3)));
      end else begin
        n = int'($urandom_range(0, DB - 1));
        hold(1'b0, OS);
        for (int i = 0; i < n; i++) hold(rb[i], OS);
        hold(rb[n], int'($urandom_range(1, OS - 1)));
        pulse_reset();
      end
      hold(1'b1, int'($urandom_range(0, 20)));
    end
    hold(1'b1, OS * 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: number of baud_clk cycles per serial bit; even, >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload bits per frame.
REQ-003 SHALL have port baud_clk  input  1: single clock at OVERSAMPLE x bit rate; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_in  input  1: serial line; asynchronous to baud_clk; idle high.
REQ-006 SHALL have port data_out  output  DATA_BITS: last correctly framed byte, LSB received first.
REQ-007 SHALL have port data_valid  output  1: one-cycle pulse when data_out updates.
REQ-008 SHALL have port frame_err  output  1: one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-010 SHALL pass rx_in through a 2-flop synchronizer (rx_s) and keep a registered copy of it (rx_prev) for edge detection; all decisions SHALL use rx_s only.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, with a tick counter cnt (0..OVERSAMPLE-1) and a bit index idx (0..DATA_BITS-1).
REQ-012 IDLE: on rx_prev=1 and rx_s=0, go to START with cnt=0; a line held low SHALL NOT retrigger.
REQ-013 START: cnt increments each cycle; at cnt=OVERSAMPLE/2-1, sample rx_s: 0 -> DATA with cnt=0 and idx=0; 1 -> IDLE as a glitch, with no output pulse.
REQ-014 DATA: at cnt=OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift) and reset cnt to 0.
REQ-015 DATA, on the same sample: if idx=DATA_BITS-1 go to STOP, else increment idx.
REQ-016 STOP: at cnt=OVERSAMPLE-1, sample rx_s and return to IDLE.
REQ-017 STOP sample 1: on the same edge, load data_out from the shift register and set data_valid=1 for exactly one cycle.
REQ-018 STOP sample 0: set frame_err=1 for exactly one cycle; data_out SHALL hold its previous value.
REQ-019 data_valid and frame_err SHALL never be high in the same cycle.
REQ-020 Latency: data_valid rises OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE + 1 cycles after the first rx_s-low cycle (153 at defaults), excluding the 2-cycle synchronizer delay.
REQ-021 Back-to-back frames: a start edge in the first IDLE cycle after STOP SHALL be accepted, with no required idle gap beyond the stop-bit half.
REQ-022 cnt and idx SHALL never wrap past their maxima; arithmetic SHALL be unsigned, using $clog2-sized widths.

Reset
REQ-023 On rst_n=0, SHALL asynchronously set state=IDLE, cnt=0, idx=0, shift register=0, data_out=0, data_valid=0, frame_err=0, busy=0.
REQ-024 Both synchronizer flops and rx_prev SHALL reset to 1 (idle line), so that release from reset does not create a false start edge.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no data_valid or frame_err pulse; reception SHALL resume on the next falling edge after release.

Structure
REQ-026 SHALL place the state encoding localparams (IDLE, START, DATA, STOP) and default OVERSAMPLE/DATA_BITS values in the shared package uart_pkg, which is used by the transmitter as well.
REQ-027 SHALL instantiate one sub-module, sync_2ff (parameterised reset value), for the rx_in synchronizer.
REQ-028 Estimated size: roughly 150-250 RTL lines.

Verification
REQ-029 Frame 0xA5 with stop=1 at 16x -> data_valid pulse once, data_out=0xA5, frame_err=0, busy falls on the same edge.
REQ-030 rx_in low for 4 cycles, then high -> returns to IDLE, no pulses, data_out unchanged.
REQ-031 Frame 0x3C with stop bit driven 0 -> frame_err pulses once, data_valid stays 0, data_out keeps its prior value.
REQ-032 Frames 0x00 then 0xFF, with the next start edge immediately after the stop-bit midpoint -> two data_valid pulses, carrying 0x00 then 0xFF.
REQ-033 rst_n pulsed low during data bit 3 of 0x5A, then a clean 0xC3 frame -> no pulse for the aborted frame, then data_out=0xC3 with one data_valid.
REQ-034 Loopback with the team's uart_tx sending 0x81 (bit period phase offset by 7 cycles) -> data_out=0x81, no frame_err.
